imem_response_router: RTL and testbench

- Memory-side responder for the shared instruction memory. It sits behind the round-robin arbiter.
- Takes the one-hot grant plus per-requester fetch addresses and issues a single memory read per cycle.
- Tracks which requester owns each in-flight read through a fixed-latency tag pipeline.
- Steers returning data into a per-requester one-entry response buffer with valid/ready handshake.
- Drives a busy mask back toward the arbiter, so a requester with an outstanding or unconsumed fetch cannot be granted again.

---
 rtl/imem_response_router.sv | 100 ++++++++++
 tb/tb_imem_response_router.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_response_router.sv
// Instruction-memory responder: issues one read per cycle, tracks ownership through a
// fixed-latency tag pipeline and buffers each requester's response. `IMEM_RSP_ERR_CHECK_EN adds a sticky err flag.
module imem_response_router #(
  parameter int N       = 3,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    gnt,
  input  logic [N*AW-1:0] req_addr,
  output logic [N-1:0]    busy,
  output logic            mem_en,
  output logic [AW-1:0]   mem_addr,
  input  logic [DW-1:0]   mem_rdata,
  output logic [N-1:0]    rsp_vld,
  output logic [N*DW-1:0] rsp_data,
  input  logic [N-1:0]    rsp_rdy
`ifdef IMEM_RSP_ERR_CHECK_EN
  ,
  output logic            err
`endif
);

  logic                 one_hot;
  logic                 issue;
  logic [N-1:0]         stage_in;
  logic [N-1:0]         tag_last;
  logic [N-1:0]         tag_any;
  logic [LATENCY*N-1:0] tag_q;

  assign one_hot  = (gnt != '0) && ((gnt & (gnt - N'(1))) == '0);
  assign issue    = one_hot && ((gnt & busy) == '0) && !rst;
  assign mem_en   = issue;
  assign stage_in = issue ? gnt : '0;
  assign tag_last = tag_q[LATENCY*N-1 -: N];

  always_comb begin
    mem_addr = '0;
    if (issue) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (gnt[i]) mem_addr = req_addr[i*AW +: AW];
      end
    end
  end

  // Stages are packed flat, stage 0 in the low N bits, so the last stage is the top slice.
  generate
    if (LATENCY == 1) begin : g_tag_single
      always_ff @(posedge clk) begin
        if (rst) tag_q <= '0;
        else     tag_q <= stage_in;
      end
    end else begin : g_tag_shift
      always_ff @(posedge clk) begin
        if (rst) tag_q <= '0;
        else     tag_q <= {tag_q[(LATENCY-1)*N-1:0], stage_in};
      end
    end
  endgenerate

  always_comb begin
    tag_any = '0;
    for (int unsigned k = 0; k < LATENCY; k++) begin
      tag_any = tag_any | tag_q[k*N +: N];
    end
  end

  assign busy = rsp_vld | tag_any;

  // Retire takes priority over consume on the same buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld  <= '0;
      rsp_data <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (tag_last[i]) begin
          rsp_vld[i]             <= 1'b1;
          rsp_data[i*DW +: DW]   <= mem_rdata;
        end else if (rsp_rdy[i]) begin
          rsp_vld[i]             <= 1'b0;
        end
      end
    end
  end

`ifdef IMEM_RSP_ERR_CHECK_EN
  logic illegal;

  assign illegal = (gnt != '0) && (!one_hot || ((gnt & busy) != '0));

  always_ff @(posedge clk) begin
    if (rst)          err <= 1'b0;
    else if (illegal) err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_imem_response_router.sv
// Bench for imem_response_router (N=3, LATENCY=2): vector table, hand sequences and a
// randomized run checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_imem_response_router;

  localparam int N   = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    gnt;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    busy;
  logic            mem_en;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_rdata;
  logic [N-1:0]    rsp_vld;
  logic [N*DW-1:0] rsp_data;
  logic [N-1:0]    rsp_rdy;
`ifdef IMEM_RSP_ERR_CHECK_EN
  logic            err;
`endif

  always #5 clk = ~clk;

  imem_response_router #(
    .N(N), .AW(AW), .DW(DW), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .gnt(gnt), .req_addr(req_addr), .busy(busy),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_rdy(rsp_rdy)
`ifdef IMEM_RSP_ERR_CHECK_EN
    , .err(err)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: per-requester buffers plus a queue of outstanding reads with due cycle.
  logic [N-1:0]  m_vld;
  logic [DW-1:0] m_data [N];
  int            q_req [$];
  longint        q_due [$];
  longint        cyc;
  logic          m_err;
  bit            chk_en;

  logic            obs_en;
  logic [AW-1:0]   obs_addr;
  logic [N-1:0]    obs_busy;
  logic [N-1:0]    obs_vld;
  logic [N*DW-1:0] obs_data;
  logic            obs_err;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_cycle(input logic r, input logic [N-1:0] g, input logic [N-1:0] rd,
                          input logic [DW-1:0] d);
    logic [N-1:0]    mb;
    logic            iss;
    int              gi;
    logic [AW-1:0]   ea;
    logic [N*DW-1:0] ed;
    logic [N-1:0]    cons;
    logic [N-1:0]    ret;
    rst = r; gnt = g; rsp_rdy = rd; mem_rdata = d;
    #2;
    mb = m_vld;
    foreach (q_req[j]) mb[q_req[j]] = 1'b1;
    iss = !r && ($countones(g) == 1) && ((g & mb) == '0);
    gi = 0;
    for (int i = 0; i < N; i++) if (g[i]) gi = i;
    ea = iss ? req_addr[gi*AW +: AW] : '0;
    for (int i = 0; i < N; i++) ed[i*DW +: DW] = m_data[i];
    obs_en = mem_en; obs_addr = mem_addr; obs_busy = busy;
    obs_vld = rsp_vld; obs_data = rsp_data;
`ifdef IMEM_RSP_ERR_CHECK_EN
    obs_err = err;
`else
    obs_err = 1'b0;
`endif
    if (chk_en) begin
      chk("model_mem_en", 128'(obs_en), 128'(iss));
      chk("model_mem_addr", 128'(obs_addr), 128'(ea));
      chk("model_busy", 128'(obs_busy), 128'(mb));
      chk("model_rsp_vld", 128'(obs_vld), 128'(m_vld));
      chk("model_rsp_data", 128'(obs_data), 128'(ed));
`ifdef IMEM_RSP_ERR_CHECK_EN
      chk("model_err", 128'(obs_err), 128'(m_err));
`endif
    end
    @(posedge clk);
    if (r) begin
      q_req.delete(); q_due.delete();
      m_vld = '0; m_err = 1'b0;
      foreach (m_data[i]) m_data[i] = '0;
    end else begin
      cons = m_vld & rd;
      ret  = '0;
      while (q_due.size() > 0 && q_due[0] == cyc) begin
        ret[q_req[0]]    = 1'b1;
        m_data[q_req[0]] = d;
        void'(q_req.pop_front());
        void'(q_due.pop_front());
      end
      m_vld = (m_vld & ~cons) | ret;
      if (iss) begin
        q_req.push_back(gi);
        q_due.push_back(cyc + LAT);
      end
      if (g != '0 && !iss) m_err = 1'b1;
    end
    cyc++;
    #1;
  endtask

  typedef struct {
    logic            r;
    logic [N-1:0]    g;
    logic [N-1:0]    rd;
    logic [DW-1:0]   d;
    logic            e_en;
    logic [AW-1:0]   e_addr;
    logic [N-1:0]    e_busy;
    logic [N-1:0]    e_vld;
    logic [N*DW-1:0] e_data;
    logic            e_err;
  } vec_t;

  localparam logic [DW-1:0] A = 32'hA000_0001, B = 32'hB000_0002;
  localparam logic [DW-1:0] C = 32'hC000_0003, D = 32'hD000_0004;
  localparam logic [DW-1:0] Z = 32'h0;

  vec_t tbl [13];

  initial begin
    rst = 1'b1; gnt = '0; rsp_rdy = '0; mem_rdata = '0;
    req_addr = {32'h0000_00C0, 32'h0000_0080, 32'h0000_0040};
    m_vld = '0; m_err = 1'b0; cyc = 0; chk_en = 1'b0;
    foreach (m_data[i]) m_data[i] = '0;

    // back-to-back issue, backpressure, busy drop, re-issue, multi-hot drop
    tbl[0]  = '{1'b0, 3'b001, 3'b000, Z, 1'b1, 32'h40, 3'b000, 3'b000, {Z, Z, Z}, 1'b0};
    tbl[1]  = '{1'b0, 3'b010, 3'b000, Z, 1'b1, 32'h80, 3'b001, 3'b000, {Z, Z, Z}, 1'b0};
    tbl[2]  = '{1'b0, 3'b100, 3'b000, A, 1'b1, 32'hC0, 3'b011, 3'b000, {Z, Z, Z}, 1'b0};
    tbl[3]  = '{1'b0, 3'b000, 3'b000, B, 1'b0, 32'h0,  3'b111, 3'b001, {Z, Z, A}, 1'b0};
    tbl[4]  = '{1'b0, 3'b000, 3'b000, C, 1'b0, 32'h0,  3'b111, 3'b011, {Z, B, A}, 1'b0};
    tbl[5]  = '{1'b0, 3'b001, 3'b000, Z, 1'b0, 32'h0,  3'b111, 3'b111, {C, B, A}, 1'b0};
    tbl[6]  = '{1'b0, 3'b000, 3'b000, Z, 1'b0, 32'h0,  3'b111, 3'b111, {C, B, A}, 1'b1};
    tbl[7]  = '{1'b0, 3'b000, 3'b001, Z, 1'b0, 32'h0,  3'b111, 3'b111, {C, B, A}, 1'b1};
    tbl[8]  = '{1'b0, 3'b001, 3'b000, Z, 1'b1, 32'h40, 3'b110, 3'b110, {C, B, A}, 1'b1};
    tbl[9]  = '{1'b0, 3'b011, 3'b110, Z, 1'b0, 32'h0,  3'b111, 3'b110, {C, B, A}, 1'b1};
    tbl[10] = '{1'b0, 3'b000, 3'b000, D, 1'b0, 32'h0,  3'b001, 3'b000, {C, B, A}, 1'b1};
    tbl[11] = '{1'b0, 3'b000, 3'b000, Z, 1'b0, 32'h0,  3'b001, 3'b001, {C, B, D}, 1'b1};
    tbl[12] = '{1'b0, 3'b000, 3'b001, Z, 1'b0, 32'h0,  3'b001, 3'b001, {C, B, D}, 1'b1};

    @(posedge clk); #1;
    do_cycle(1'b1, 3'b001, '0, '0);
    chk_en = 1'b1;
    do_cycle(1'b1, 3'b001, '0, '0);
    chk("reset_mem_en", 128'(obs_en), 128'(0));
    chk("reset_busy", 128'(obs_busy), 128'(0));
    chk("reset_rsp_vld", 128'(obs_vld), 128'(0));
    chk("reset_rsp_data", 128'(obs_data), 128'(0));

    for (int i = 0; i < 13; i++) begin
      do_cycle(tbl[i].r, tbl[i].g, tbl[i].rd, tbl[i].d);
      chk($sformatf("tbl%0d_mem_en", i), 128'(obs_en), 128'(tbl[i].e_en));
      chk($sformatf("tbl%0d_mem_addr", i), 128'(obs_addr), 128'(tbl[i].e_addr));
      chk($sformatf("tbl%0d_busy", i), 128'(obs_busy), 128'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_rsp_vld", i), 128'(obs_vld), 128'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_rsp_data", i), 128'(obs_data), 128'(tbl[i].e_data));
`ifdef IMEM_RSP_ERR_CHECK_EN
      chk($sformatf("tbl%0d_err", i), 128'(obs_err), 128'(tbl[i].e_err));
`endif
    end

    // single fetch for requester 1
    do_cycle(1'b1, '0, '0, '0);
    req_addr[1*AW +: AW] = 32'h0000_0040;
    do_cycle(1'b0, 3'b010, '0, '0);
`ifdef IMEM_RSP_ERR_CHECK_EN
    chk("single_err_cleared", 128'(obs_err), 128'(0));
`endif
    chk("single_mem_en", 128'(obs_en), 128'(1));
    chk("single_mem_addr", 128'(obs_addr), 128'(32'h40));
    do_cycle(1'b0, '0, '0, '0);
    chk("single_busy_t1", 128'(obs_busy), 128'(3'b010));
    do_cycle(1'b0, '0, '0, 32'hDEAD_BEEF);
    chk("single_vld_t2", 128'(obs_vld), 128'(3'b000));
    do_cycle(1'b0, '0, '0, '0);
    chk("single_vld_t3", 128'(obs_vld), 128'(3'b010));
    chk("single_data_t3", 128'(obs_data[1*DW +: DW]), 128'(32'hDEAD_BEEF));
    do_cycle(1'b0, '0, 3'b010, '0);
    chk("single_busy_hold", 128'(obs_busy), 128'(3'b010));
    do_cycle(1'b0, '0, '0, '0);
    chk("single_busy_free", 128'(obs_busy), 128'(3'b000));
    chk("single_data_kept", 128'(obs_data[1*DW +: DW]), 128'(32'hDEAD_BEEF));

    // reset while a read is in flight
    do_cycle(1'b0, 3'b100, '0, '0);
    chk("rstmid_issue", 128'(obs_en), 128'(1));
    do_cycle(1'b1, '0, '0, '0);
    chk("rstmid_busy_before", 128'(obs_busy), 128'(3'b100));
    do_cycle(1'b0, '0, '0, 32'h1234_5678);
    chk("rstmid_busy_after", 128'(obs_busy), 128'(3'b000));
    do_cycle(1'b0, '0, '0, '0);
    chk("rstmid_vld", 128'(obs_vld), 128'(3'b000));
    chk("rstmid_data", 128'(obs_data), 128'(0));

    // consume on requester 0 in the cycle requester 2 retires
    do_cycle(1'b0, 3'b001, '0, '0);
    do_cycle(1'b0, 3'b100, '0, '0);
    do_cycle(1'b0, '0, '0, 32'hEEEE_0000);
    do_cycle(1'b0, '0, 3'b001, 32'hFFFF_0002);
    chk("simul_vld_before", 128'(obs_vld), 128'(3'b001));
    do_cycle(1'b0, '0, '0, '0);
    chk("simul_vld_after", 128'(obs_vld), 128'(3'b100));
    chk("simul_data2", 128'(obs_data[2*DW +: DW]), 128'(32'hFFFF_0002));
    chk("simul_data0", 128'(obs_data[0 +: DW]), 128'(32'hEEEE_0000));

    // randomized traffic against the model
    for (int t = 0; t < 600; t++) begin
      logic [N-1:0] g;
      int           sel;
      for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = $urandom;
      sel = $urandom_range(0, 9);
      if (sel < 2)       g = '0;
      else if (sel < 8)  g = N'(1) << $urandom_range(0, N-1);
      else if (sel == 8) g = N'(3) << $urandom_range(0, N-2);
      else               g = '1;
      do_cycle(($urandom_range(0, 59) == 0), g, N'($urandom), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
